// File: rtl/serial_sub8.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor stage and reports borrow-out and signed overflow.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic d;
  logic br_next;

  assign ai      = sa[0];
  assign bi      = sb[0];
  assign d       = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          res <= {d, res[WIDTH-1:1]};
          if (cnt == LAST) begin
            // On the last bit the operand LSBs are the original sign bits.
            diff  <= {d, res[WIDTH-1:1]};
            bout  <= br_next;
            ovf   <= (ai != bi) && (d != ai);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and random checks of serial_sub8: vector table, busy/start-ignore,
// asynchronous reset abort and back-to-back regression against an arithmetic model.
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo);
    logic [9:0] prev;
    int lat;
    int bcnt;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    prev  = {ovf, bout, diff};
    a     = ta;
    b     = tbv;
    bin   = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
    lat   = 0;
    bcnt  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (lat == 8) check("hold_during_shift", 32'({ovf, bout, diff}), 32'(prev));
    end while (!done && lat < 40);
    check("latency", 32'(lat), 32'd9);
    check("busy_cycles", 32'(bcnt), 32'd8);
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
  endtask

  task automatic model_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin);
    logic [8:0] r;
    logic [7:0] ed;
    logic       eo;
    r  = {1'b0, ta} - {1'b0, tbv} - {8'd0, tbin};
    ed = r[7:0];
    eo = (ta[7] != tbv[7]) && (ed[7] != ta[7]);
    run_op(ta, tbv, tbin, ed, r[8], eo);
  endtask

  initial begin
    int ndone;
    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({busy, done, ovf, bout, diff}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].ed, vecs[i].eb, vecs[i].eo);

    // start pulsed with new operands while busy must be ignored
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == 3) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (done) ndone++;
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);
    check("ignored_start_diff", 32'(diff), 32'h02);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midshift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({busy, done, ovf, bout, diff}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // first start after reset accepted, then back-to-back random regression
    model_op(8'h5A, 8'hA5, 1'b1);
    for (int i = 0; i < 1000; i++)
      model_op(8'($urandom), 8'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
